// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 transmit controller.
package rs485_pkg;

   // Payload bits per UART 8N1 frame.
   localparam int DATA_BITS = 8;

   // Transmit FSM states, in frame order.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4,
      ST_TRAIL = 3'd5
   } tx_state_e;

   // Clocks per bit time (integer divide).
   function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/rs485_bit_timer.sv
// Bit-time timer: counts BPS_CNT clocks per bit, pulses bit_end_o on the
// last clock of each bit and counts completed bit times (mod 4) for the
// multi-bit LEAD/TRAIL phases. clear_i restarts both counts.
module rs485_bit_timer #(
   parameter int BPS_CNT = 434,
   parameter int CNT_W   = $clog2(BPS_CNT * 4)
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       clear_i,
   output logic       bit_end_o,
   output logic [1:0] bit_num_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       bits_q, bits_d;
   logic             bit_end_s;

   assign bit_end_s = (cnt_q == CNT_LAST);
   assign bit_end_o = bit_end_s;
   assign bit_num_o = bits_q;

   // Next counts: clear wins, otherwise wrap at the end of each bit time.
   always_comb begin
      cnt_d  = cnt_q;
      bits_d = bits_q;
      if (clear_i) begin
         cnt_d  = {CNT_W{1'b0}};
         bits_d = 2'd0;
      end else if (bit_end_s) begin
         cnt_d  = {CNT_W{1'b0}};
         bits_d = bits_q + 2'd1;
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= {CNT_W{1'b0}};
         bits_q <= 2'd0;
      end else begin
         cnt_q  <= cnt_d;
         bits_q <= bits_d;
      end
   end

endmodule

// File: rtl/rs485_tx_ctrl.sv
// RS485 transmit controller: UART 8N1 serialiser that owns the transceiver
// direction pins, keeping the driver enabled for a lead time before the
// start bit and a trail time after the last stop bit. Back-to-back bytes
// are chained without dropping DE.
module rs485_tx_ctrl
   import rs485_pkg::*;
#(
   parameter int CLK_FREQ      = 50000000,
   parameter int UART_BPS      = 115200,
   parameter int DE_LEAD_BITS  = 1,
   parameter int DE_TRAIL_BITS = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       rs485_uart_txd,
   output logic       rs485_de,
   output logic       rs485_re_n
);

   localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam int CNT_W   = $clog2(BPS_CNT * 4);

   // Last bit-time index of LEAD/TRAIL (only used when the phase exists).
   localparam int          LEAD_LAST_I  = (DE_LEAD_BITS > 0)  ? DE_LEAD_BITS - 1  : 0;
   localparam int          TRAIL_LAST_I = (DE_TRAIL_BITS > 0) ? DE_TRAIL_BITS - 1 : 0;
   localparam logic [1:0]  LEAD_LAST    = 2'(LEAD_LAST_I);
   localparam logic [1:0]  TRAIL_LAST   = 2'(TRAIL_LAST_I);
   localparam logic [2:0]  BIT_LAST     = 3'(DATA_BITS - 1);

   if (BPS_CNT < 2) begin : g_bps_check
      $error("rs485_tx_ctrl: CLK_FREQ/UART_BPS must be at least 2");
   end
   if ((DE_LEAD_BITS < 0) || (DE_LEAD_BITS > 3) ||
       (DE_TRAIL_BITS < 0) || (DE_TRAIL_BITS > 3)) begin : g_de_check
      $error("rs485_tx_ctrl: DE_LEAD_BITS/DE_TRAIL_BITS must be 0..3");
   end

   tx_state_e  state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       txd_q, txd_d;
   logic       de_q, de_d;
   logic       busy_q;
   logic       re_n_q;

   logic       bit_end_s;
   logic [1:0] bit_num_s;
   logic       timer_clear_s;
   logic       ready_s;
   logic       accept_s;

   // Ready in IDLE, and on the last STOP clock so a waiting byte chains on.
   assign ready_s  = (state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end_s);
   assign accept_s = tx_valid & ready_s;
   // Timer restarts on every state change and stays parked while idle.
   assign timer_clear_s = (state_q == ST_IDLE) | (state_d != state_q);

   rs485_bit_timer #(
      .BPS_CNT (BPS_CNT),
      .CNT_W   (CNT_W)
   ) u_bit_timer (
      .clk_i     (sys_clk),
      .rst_n_i   (sys_rst_n),
      .clear_i   (timer_clear_s),
      .bit_end_o (bit_end_s),
      .bit_num_o (bit_num_s)
   );

   // Next-state, byte latch and bit index.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               data_d  = tx_data;
               state_d = (DE_LEAD_BITS > 0) ? ST_LEAD : ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LEAD: begin
            if (bit_end_s && (bit_num_s == LEAD_LAST)) begin
               state_d = ST_START;
            end else begin
               state_d = ST_LEAD;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end else begin
               state_d   = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               if (bit_idx_q == BIT_LAST) begin
                  state_d   = ST_STOP;
                  bit_idx_d = 3'd0;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               if (accept_s) begin
                  data_d  = tx_data;
                  state_d = ST_START;
               end else begin
                  state_d = (DE_TRAIL_BITS > 0) ? ST_TRAIL : ST_IDLE;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_TRAIL: begin
            if (bit_end_s && (bit_num_s == TRAIL_LAST)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_TRAIL;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_idx_d = 3'd0;
         end
      endcase
   end

   // Output values for the coming state, so the pins change on the same edge.
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = data_q[bit_idx_d];
         default:  txd_d = 1'b1;
      endcase
      de_d = (state_d != ST_IDLE);
   end

   // State, data and registered pin drivers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         data_q    <= 8'h00;
         bit_idx_q <= 3'd0;
         txd_q     <= 1'b1;
         de_q      <= 1'b0;
         busy_q    <= 1'b0;
         re_n_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         de_q      <= de_d;
         busy_q    <= de_d;
         re_n_q    <= de_d;
      end
   end

   assign tx_ready       = ready_s;
   assign tx_busy        = busy_q;
   assign rs485_uart_txd = txd_q;
   assign rs485_de       = de_q;
   assign rs485_re_n     = re_n_q;

endmodule

// File: tb/tb_rs485_tx_ctrl.sv
// Directed bench for rs485_tx_ctrl: BPS_CNT=10, one instance with
// LEAD=TRAIL=1 and one with LEAD=TRAIL=0. Cycle 0 is the acceptance cycle;
// outputs are sampled 1 time unit after each rising edge.
module tb_rs485_tx_ctrl;

   localparam int BPS = 10;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       v1, v0;
   logic [7:0] d1, d0;
   logic       rdy1, busy1, txd1, de1, ren1;
   logic       rdy0, busy0, txd0, de0, ren0;

   always #5 sys_clk = ~sys_clk;

   rs485_tx_ctrl #(.CLK_FREQ(1000000), .UART_BPS(100000),
                   .DE_LEAD_BITS(1), .DE_TRAIL_BITS(1)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(v1), .tx_data(d1),
      .tx_ready(rdy1), .tx_busy(busy1), .rs485_uart_txd(txd1),
      .rs485_de(de1), .rs485_re_n(ren1));

   rs485_tx_ctrl #(.CLK_FREQ(1000000), .UART_BPS(100000),
                   .DE_LEAD_BITS(0), .DE_TRAIL_BITS(0)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_valid(v0), .tx_data(d0),
      .tx_ready(rdy0), .tx_busy(busy0), .rs485_uart_txd(txd0),
      .rs485_de(de0), .rs485_re_n(ren0));

   bit   sel;
   logic txd_s, de_s, busy_s, rdy_s, ren_s;

   // Observe whichever instance the current test targets.
   always_comb begin
      if (sel) begin
         txd_s = txd0; de_s = de0; busy_s = busy0; rdy_s = rdy0; ren_s = ren0;
      end else begin
         txd_s = txd1; de_s = de1; busy_s = busy1; rdy_s = rdy1; ren_s = ren1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   logic txd_a  [0:255];
   logic de_a   [0:255];
   logic busy_a [0:255];
   logic rdy_a  [0:255];
   logic ren_a  [0:255];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      if (sel) begin v0 = v; d0 = d; end
      else     begin v1 = v; d1 = d; end
   endtask

   task automatic record(input int c);
      txd_a[c] = txd_s; de_a[c] = de_s; busy_a[c] = busy_s;
      rdy_a[c] = rdy_s; ren_a[c] = ren_s;
   endtask

   // Offer first_b at cycle 0, switch tx_data to second_b at cycle 1,
   // drop tx_valid at cycle drop_at, and record outputs for cycles 0..ncyc.
   task automatic capture(input logic [7:0] first_b, input logic [7:0] second_b,
                          input int drop_at, input int ncyc);
      logic       vcur;
      logic [7:0] dcur;
      vcur = 1'b1;
      dcur = first_b;
      drive(vcur, dcur);
      #0;
      record(0);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge sys_clk);
         #1;
         if (c == 1) dcur = second_b;
         if (c == drop_at) vcur = 1'b0;
         drive(vcur, dcur);
         record(c);
      end
   endtask

   // Byte read from mid-bit samples of a frame whose start bit begins at s.
   function automatic logic [7:0] frame_byte(input int s);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = txd_a[s + BPS + BPS * i + BPS / 2];
      return b;
   endfunction

   function automatic int count_de(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (de_a[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int count_busy(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (busy_a[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int count_txd_low(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (txd_a[i] === 1'b0) n++;
      return n;
   endfunction

   initial begin
      sel = 1'b0;
      v1 = 1'b0; v0 = 1'b0; d1 = 8'h00; d0 = 8'h00;
      sys_rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check_val("rst_txd",  32'(txd1),  32'd1);
      check_val("rst_de",   32'(de1),   32'd0);
      check_val("rst_re_n", 32'(ren1),  32'd0);
      check_val("rst_busy", 32'(busy1), 32'd0);
      check_val("rst_rdy",  32'(rdy1),  32'd1);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;

      // Single byte 0xA5 with one bit of lead and trail.
      capture(8'hA5, 8'hA5, 1, 125);
      check_val("a5_rdy0",      32'(rdy_a[0]),   32'd1);
      check_val("a5_de1",       32'(de_a[1]),    32'd1);
      check_val("a5_busy1",     32'(busy_a[1]),  32'd1);
      check_val("a5_ren1",      32'(ren_a[1]),   32'd1);
      check_val("a5_rdy1",      32'(rdy_a[1]),   32'd0);
      check_val("a5_lead_txd1", 32'(txd_a[1]),   32'd1);
      check_val("a5_lead_txd10",32'(txd_a[10]),  32'd1);
      check_val("a5_start11",   32'(txd_a[11]),  32'd0);
      check_val("a5_start20",   32'(txd_a[20]),  32'd0);
      check_val("a5_bit0_21",   32'(txd_a[21]),  32'd1);
      check_val("a5_bit1_31",   32'(txd_a[31]),  32'd0);
      check_val("a5_byte",      32'(frame_byte(11)), 32'h0000_00A5);
      check_val("a5_stop101",   32'(txd_a[101]), 32'd1);
      check_val("a5_stop110",   32'(txd_a[110]), 32'd1);
      check_val("a5_rdy109",    32'(rdy_a[109]), 32'd0);
      check_val("a5_rdy110",    32'(rdy_a[110]), 32'd1);
      check_val("a5_trail_de120",  32'(de_a[120]),  32'd1);
      check_val("a5_trail_rdy120", 32'(rdy_a[120]), 32'd0);
      check_val("a5_idle_de121",   32'(de_a[121]),  32'd0);
      check_val("a5_idle_busy121", 32'(busy_a[121]),32'd0);
      check_val("a5_idle_ren121",  32'(ren_a[121]), 32'd0);
      check_val("a5_idle_rdy121",  32'(rdy_a[121]), 32'd1);
      check_val("a5_de_cycles",    32'(count_de(1, 125)),   32'd120);
      check_val("a5_busy_cycles",  32'(count_busy(1, 125)), 32'd120);

      // Back-to-back 0x01 then 0xFF: one LEAD, one TRAIL, DE never drops.
      capture(8'h01, 8'hFF, 111, 225);
      check_val("b2b_stop110",   32'(txd_a[110]), 32'd1);
      check_val("b2b_rdy110",    32'(rdy_a[110]), 32'd1);
      check_val("b2b_start111",  32'(txd_a[111]), 32'd0);
      check_val("b2b_start120",  32'(txd_a[120]), 32'd0);
      check_val("b2b_byte1",     32'(frame_byte(11)),  32'h0000_0001);
      check_val("b2b_byte2",     32'(frame_byte(111)), 32'h0000_00FF);
      check_val("b2b_stop210",   32'(txd_a[210]), 32'd1);
      check_val("b2b_de220",     32'(de_a[220]),  32'd1);
      check_val("b2b_de221",     32'(de_a[221]),  32'd0);
      check_val("b2b_de_cycles", 32'(count_de(1, 225)),      32'd220);
      check_val("b2b_txd_low",   32'(count_txd_low(1, 225)), 32'd90);

      // Byte offered during TRAIL waits for IDLE and gets a fresh LEAD.
      capture(8'h55, 8'h55, 1, 115);
      drive(1'b1, 8'h96);
      #0;
      check_val("trail_rdy115", 32'(rdy_s), 32'd0);
      repeat (5) begin @(posedge sys_clk); #1; end
      check_val("trail_rdy120", 32'(rdy_s), 32'd0);
      check_val("trail_de120",  32'(de_s),  32'd1);
      check_val("trail_txd120", 32'(txd_s), 32'd1);
      @(posedge sys_clk);
      #1;
      check_val("trail_idle_rdy", 32'(rdy_s), 32'd1);
      check_val("trail_idle_de",  32'(de_s),  32'd0);
      capture(8'h96, 8'h96, 1, 125);
      check_val("late_lead_de1",   32'(de_a[1]),   32'd1);
      check_val("late_lead_txd10", 32'(txd_a[10]), 32'd1);
      check_val("late_start11",    32'(txd_a[11]), 32'd0);
      check_val("late_byte",       32'(frame_byte(11)), 32'h0000_0096);
      check_val("late_de121",      32'(de_a[121]), 32'd0);

      // tx_data changes after acceptance; frame keeps 0x81.
      capture(8'h81, 8'h00, 1, 125);
      check_val("hold_byte",  32'(frame_byte(11)), 32'h0000_0081);
      check_val("hold_bit7",  32'(txd_a[95]), 32'd1);

      // No lead/trail: start bit right after acceptance.
      sel = 1'b1;
      capture(8'h00, 8'h00, 1, 105);
      check_val("nolead_rdy0",    32'(rdy_a[0]),   32'd1);
      check_val("nolead_txd1",    32'(txd_a[1]),   32'd0);
      check_val("nolead_de1",     32'(de_a[1]),    32'd1);
      check_val("nolead_byte",    32'(frame_byte(1)), 32'h0000_0000);
      check_val("nolead_txd90",   32'(txd_a[90]),  32'd0);
      check_val("nolead_stop91",  32'(txd_a[91]),  32'd1);
      check_val("nolead_de100",   32'(de_a[100]),  32'd1);
      check_val("nolead_rdy100",  32'(rdy_a[100]), 32'd1);
      check_val("nolead_de101",   32'(de_a[101]),  32'd0);
      check_val("nolead_busy101", 32'(busy_a[101]),32'd0);
      check_val("nolead_de_cycles", 32'(count_de(1, 105)), 32'd100);
      sel = 1'b0;

      // Reset during data bit 4 of 0xA5, then a clean 0x3C frame.
      drive(1'b1, 8'hA5);
      @(posedge sys_clk);
      #1;
      drive(1'b0, 8'hA5);
      repeat (64) begin @(posedge sys_clk); #1; end
      check_val("mid_de65",  32'(de_s),  32'd1);
      check_val("mid_txd65", 32'(txd_s), 32'd0);
      #2 sys_rst_n = 1'b0;
      #1;
      check_val("arst_txd",  32'(txd_s),  32'd1);
      check_val("arst_de",   32'(de_s),   32'd0);
      check_val("arst_ren",  32'(ren_s),  32'd0);
      check_val("arst_busy", 32'(busy_s), 32'd0);
      @(posedge sys_clk);
      #1;
      check_val("arst_rdy", 32'(rdy_s), 32'd1);
      @(negedge sys_clk) sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      check_val("post_rst_rdy", 32'(rdy_s), 32'd1);
      check_val("post_rst_txd", 32'(txd_s), 32'd1);
      capture(8'h3C, 8'h3C, 1, 125);
      check_val("post_de1",     32'(de_a[1]),   32'd1);
      check_val("post_start11", 32'(txd_a[11]), 32'd0);
      check_val("post_byte",    32'(frame_byte(11)), 32'h0000_003C);
      check_val("post_stop101", 32'(txd_a[101]), 32'd1);
      check_val("post_de121",   32'(de_a[121]), 32'd0);
      check_val("post_de_cycles", 32'(count_de(1, 125)), 32'd120);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
